// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage FSM states, PC width and default NOP encoding
package fetch_pkg;
    localparam int PC_W = 32;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with redirect (priority) and +4 advance
// Ports: clk, rst (async active-low), redirect/target (word-aligned on load),
//        advance (PC+4, modulo 2^32), pc (current fetch address)
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [PC_W-1:0] target,
    input  logic            advance,
    output logic [PC_W-1:0] pc
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC & ~PC_W'(3);
        else if (redirect) pc <= target & ~PC_W'(3);
        else if (advance) pc <= pc + PC_W'(4);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM feeding the IF/ID register
// Ports: clk, rst (async active-low); en_F (downstream accept), PCSrc_E/PCTarget_E (redirect);
//        imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata (memory handshake);
//        instr_F/PC_F/PCPlus4_F/valid_F (held instruction, zeroed/NOP while not valid)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = NOP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_F,
    input  logic            PCSrc_E,
    input  logic [PC_W-1:0] PCTarget_E,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_F,
    output logic [PC_W-1:0] PC_F,
    output logic [PC_W-1:0] PCPlus4_F,
    output logic            valid_F
);
    state_t          state, state_n;
    logic            discard, discard_n, load;
    logic [PC_W-1:0] pc, pcf_q, pc4_q;
    logic [31:0]     instr_q;

    // PC is only moved on redirect or on consuming the held instruction, so while
    // waiting it still names the address of the outstanding request
    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk     (clk),
        .rst     (rst),
        .redirect(PCSrc_E),
        .target  (PCTarget_E),
        .advance (state == HOLD && en_F),
        .pc      (pc)
    );

    always_comb begin
        state_n   = state;
        discard_n = discard;
        load      = 1'b0;
        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                state_n   = imem_gnt ? WAIT : REQ;
                discard_n = imem_gnt && PCSrc_E;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    // a response for a redirected-away address is dropped
                    load      = !discard && !PCSrc_E;
                    state_n   = load ? HOLD : REQ;
                    discard_n = 1'b0;
                end else begin
                    discard_n = discard || PCSrc_E;
                end
            end
            HOLD: state_n = (PCSrc_E || en_F) ? REQ : HOLD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            discard <= 1'b0;
            instr_q <= NOP_INSTR;
            pcf_q   <= '0;
            pc4_q   <= '0;
        end else begin
            state   <= state_n;
            discard <= discard_n;
            if (load) begin
                instr_q <= imem_rdata;
                pcf_q   <= pc;
                pc4_q   <= pc + PC_W'(4);
            end
        end
    end

    // a real instruction is held exactly while in HOLD
    assign valid_F   = state == HOLD;
    assign imem_req  = state == REQ;
    assign imem_addr = pc;
    assign instr_F   = valid_F ? instr_q : NOP_INSTR;
    assign PC_F      = valid_F ? pcf_q : '0;
    assign PCPlus4_F = valid_F ? pc4_q : '0;
endmodule
